// File: rtl/axi_slave_mem.sv
// AXI-style slave scratch memory: independent write and read burst engines,
// per-byte strobes, SLVERR on bad addresses/lengths, and an in-order read-request queue.
module axi_slave_mem #(
    parameter int DATA_W   = 32,
    parameter int ID_W     = 4,
    parameter int ADDR_B   = 0,
    parameter int ADDR_E   = 2047,
    parameter int RD_QUEUE = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [31:0]            WR_ADDR,
    input  logic [7:0]             WR_LEN,
    input  logic [ID_W-1:0]        WR_ID,
    input  logic                   WR_ADDR_VALID,
    output logic                   WR_ADDR_READY,
    input  logic [DATA_W-1:0]      WR_DATA,
    input  logic [DATA_W/8-1:0]    WR_STRB,
    input  logic                   WR_DATA_LAST,
    input  logic                   WR_DATA_VALID,
    output logic                   WR_DATA_READY,
    output logic [ID_W-1:0]        WR_BACK_ID,
    output logic [1:0]             WR_BACK_RESP,
    output logic                   WR_BACK_VALID,
    input  logic                   WR_BACK_READY,
    input  logic [31:0]            RD_ADDR,
    input  logic [7:0]             RD_LEN,
    input  logic [ID_W-1:0]        RD_ID,
    input  logic                   RD_ADDR_VALID,
    output logic                   RD_ADDR_READY,
    output logic [DATA_W-1:0]      RD_DATA,
    output logic [ID_W-1:0]        RD_BACK_ID,
    output logic [1:0]             RD_BACK_RESP,
    output logic                   RD_DATA_LAST,
    output logic                   RD_DATA_VALID,
    input  logic                   RD_DATA_READY
);
    localparam int          STRB_W = DATA_W / 8;
    localparam int          DEPTH  = ADDR_E - ADDR_B + 1;
    localparam int          IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          QA_W   = $clog2(RD_QUEUE);
    localparam logic [31:0] A_B    = 32'(ADDR_B);
    localparam logic [31:0] A_E    = 32'(ADDR_E);
    localparam logic [31:0] SPAN   = A_E - A_B;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;
    typedef enum logic {R_IDLE = 1'b0, R_BURST = 1'b1} rstate_t;

    // Unsigned offset compare also catches addresses below ADDR_B via wraparound.
    function automatic logic in_range(input logic [31:0] a);
        return (a - A_B) <= SPAN;
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] a);
        return (a == A_E) ? A_B : a + 32'd1;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
        return IDX_W'(a - A_B);
    endfunction

    logic [DATA_W-1:0] r_mem [DEPTH] = '{default: '0};

    wstate_t           r_wstate, w_wstate_nx;
    logic [31:0]       r_waddr, w_waddr_nx;
    logic [7:0]        r_wlen, w_wlen_nx, r_wcnt, w_wcnt_nx;
    logic [ID_W-1:0]   r_wid, w_wid_nx, r_bid, w_bid_nx;
    logic              r_werr, w_werr_nx;
    logic [1:0]        r_bresp, w_bresp_nx;
    logic              r_waddr_rdy, r_wdata_rdy, r_bvalid;
    logic              w_aw_hs, w_w_hs, w_w_final;

    assign w_aw_hs   = WR_ADDR_VALID & r_waddr_rdy;
    assign w_w_hs    = WR_DATA_VALID & r_wdata_rdy;
    assign w_w_final = (r_wcnt == r_wlen);

    // Write engine next-state: address latch, beat counting, burst end and response.
    always_comb begin
        w_wstate_nx = r_wstate;
        w_waddr_nx  = r_waddr;
        w_wlen_nx   = r_wlen;
        w_wcnt_nx   = r_wcnt;
        w_wid_nx    = r_wid;
        w_werr_nx   = r_werr;
        w_bid_nx    = r_bid;
        w_bresp_nx  = r_bresp;
        case (r_wstate)
            W_IDLE: begin
                if (w_aw_hs) begin
                    w_waddr_nx  = WR_ADDR;
                    w_wlen_nx   = WR_LEN;
                    w_wid_nx    = WR_ID;
                    w_wcnt_nx   = 8'd0;
                    w_werr_nx   = !in_range(WR_ADDR);
                    w_wstate_nx = W_DATA;
                end else begin
                    w_wstate_nx = W_IDLE;
                end
            end
            W_DATA: begin
                if (w_w_hs) begin
                    w_waddr_nx = next_addr(r_waddr);
                    w_wcnt_nx  = r_wcnt + 8'd1;
                    if (WR_DATA_LAST || w_w_final) begin
                        w_werr_nx   = r_werr | (WR_DATA_LAST ^ w_w_final);
                        w_bid_nx    = r_wid;
                        w_bresp_nx  = w_werr_nx ? 2'b10 : 2'b00;
                        w_wstate_nx = W_RESP;
                    end else begin
                        w_wstate_nx = W_DATA;
                    end
                end else begin
                    w_wstate_nx = W_DATA;
                end
            end
            W_RESP: begin
                if (r_bvalid && WR_BACK_READY) begin
                    w_wstate_nx = W_IDLE;
                end else begin
                    w_wstate_nx = W_RESP;
                end
            end
            default: w_wstate_nx = W_IDLE;
        endcase
    end

    // Write engine registers; handshake outputs decode the next state so they are registered.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wstate    <= W_IDLE;
            r_waddr     <= 32'd0;
            r_wlen      <= 8'd0;
            r_wcnt      <= 8'd0;
            r_wid       <= '0;
            r_werr      <= 1'b0;
            r_bid       <= '0;
            r_bresp     <= 2'b00;
            r_waddr_rdy <= 1'b0;
            r_wdata_rdy <= 1'b0;
            r_bvalid    <= 1'b0;
        end else begin
            r_wstate    <= w_wstate_nx;
            r_waddr     <= w_waddr_nx;
            r_wlen      <= w_wlen_nx;
            r_wcnt      <= w_wcnt_nx;
            r_wid       <= w_wid_nx;
            r_werr      <= w_werr_nx;
            r_bid       <= w_bid_nx;
            r_bresp     <= w_bresp_nx;
            r_waddr_rdy <= (w_wstate_nx == W_IDLE);
            r_wdata_rdy <= (w_wstate_nx == W_DATA);
            r_bvalid    <= (w_wstate_nx == W_RESP);
        end
    end

    // Byte-strobed memory write; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_w_hs && !r_werr) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (WR_STRB[i]) begin
                    r_mem[word_idx(r_waddr)][8*i +: 8] <= WR_DATA[8*i +: 8];
                end
            end
        end
    end

    logic [32+8+ID_W-1:0] r_q [RD_QUEUE];
    logic [QA_W:0]        r_qwp, r_qrp, w_qwp_nx, w_qrp_nx;
    logic                 r_raddr_rdy, w_q_empty, w_q_full_nx, w_push, w_pop;
    logic [31:0]          w_h_addr;
    logic [7:0]           w_h_len;
    logic [ID_W-1:0]      w_h_id;

    assign w_push      = RD_ADDR_VALID & r_raddr_rdy;
    assign w_q_empty   = (r_qwp == r_qrp);
    assign w_qwp_nx    = r_qwp + (QA_W+1)'(w_push);
    assign w_qrp_nx    = r_qrp + (QA_W+1)'(w_pop);
    assign w_q_full_nx = (w_qwp_nx[QA_W] != w_qrp_nx[QA_W]) &&
                         (w_qwp_nx[QA_W-1:0] == w_qrp_nx[QA_W-1:0]);
    assign {w_h_addr, w_h_len, w_h_id} = r_q[r_qrp[QA_W-1:0]];

    // Read-request queue storage.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q[r_qwp[QA_W-1:0]] <= {RD_ADDR, RD_LEN, RD_ID};
        end
    end

    rstate_t           r_rstate, w_rstate_nx;
    logic [31:0]       r_raddr, w_raddr_nx, w_fetch_addr;
    logic [7:0]        r_rlen, w_rlen_nx, r_rcnt, w_rcnt_nx;
    logic              r_rerr, w_rerr_nx, w_fetch_err;
    logic [DATA_W-1:0] r_rdata, w_rdata_nx, w_fetch_data;
    logic [ID_W-1:0]   r_rid, w_rid_nx;
    logic [1:0]        r_rresp, w_rresp_nx;
    logic              r_rlast, w_rlast_nx, r_rvalid, w_rvalid_nx;

    // The single read port serves the queue head when idle, the running burst otherwise.
    assign w_pop        = (r_rstate == R_IDLE) && !w_q_empty;
    assign w_fetch_addr = (r_rstate == R_IDLE) ? w_h_addr : r_raddr;
    assign w_fetch_err  = (r_rstate == R_IDLE) ? !in_range(w_h_addr) : r_rerr;
    assign w_fetch_data = w_fetch_err ? '0 : r_mem[word_idx(w_fetch_addr)];

    // Read engine next-state: pop and load first beat, then advance per accepted beat.
    always_comb begin
        w_rstate_nx = r_rstate;
        w_raddr_nx  = r_raddr;
        w_rlen_nx   = r_rlen;
        w_rcnt_nx   = r_rcnt;
        w_rerr_nx   = r_rerr;
        w_rdata_nx  = r_rdata;
        w_rid_nx    = r_rid;
        w_rresp_nx  = r_rresp;
        w_rlast_nx  = r_rlast;
        w_rvalid_nx = r_rvalid;
        case (r_rstate)
            R_IDLE: begin
                if (w_pop) begin
                    w_rstate_nx = R_BURST;
                    w_raddr_nx  = next_addr(w_h_addr);
                    w_rlen_nx   = w_h_len;
                    w_rcnt_nx   = 8'd0;
                    w_rerr_nx   = w_fetch_err;
                    w_rdata_nx  = w_fetch_data;
                    w_rid_nx    = w_h_id;
                    w_rresp_nx  = w_fetch_err ? 2'b10 : 2'b00;
                    w_rlast_nx  = (w_h_len == 8'd0);
                    w_rvalid_nx = 1'b1;
                end else begin
                    w_rvalid_nx = 1'b0;
                end
            end
            R_BURST: begin
                if (r_rvalid && RD_DATA_READY) begin
                    if (r_rlast) begin
                        w_rstate_nx = R_IDLE;
                        w_rvalid_nx = 1'b0;
                        w_rlast_nx  = 1'b0;
                    end else begin
                        w_rcnt_nx  = r_rcnt + 8'd1;
                        w_rlast_nx = ((r_rcnt + 8'd1) == r_rlen);
                        w_rdata_nx = w_fetch_data;
                        w_raddr_nx = next_addr(r_raddr);
                    end
                end else begin
                    w_rstate_nx = R_BURST;
                end
            end
            default: w_rstate_nx = R_IDLE;
        endcase
    end

    // Read engine and queue pointer registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rstate    <= R_IDLE;
            r_raddr     <= 32'd0;
            r_rlen      <= 8'd0;
            r_rcnt      <= 8'd0;
            r_rerr      <= 1'b0;
            r_rdata     <= '0;
            r_rid       <= '0;
            r_rresp     <= 2'b00;
            r_rlast     <= 1'b0;
            r_rvalid    <= 1'b0;
            r_qwp       <= '0;
            r_qrp       <= '0;
            r_raddr_rdy <= 1'b0;
        end else begin
            r_rstate    <= w_rstate_nx;
            r_raddr     <= w_raddr_nx;
            r_rlen      <= w_rlen_nx;
            r_rcnt      <= w_rcnt_nx;
            r_rerr      <= w_rerr_nx;
            r_rdata     <= w_rdata_nx;
            r_rid       <= w_rid_nx;
            r_rresp     <= w_rresp_nx;
            r_rlast     <= w_rlast_nx;
            r_rvalid    <= w_rvalid_nx;
            r_qwp       <= w_qwp_nx;
            r_qrp       <= w_qrp_nx;
            r_raddr_rdy <= !w_q_full_nx;
        end
    end

    assign WR_ADDR_READY = r_waddr_rdy;
    assign WR_DATA_READY = r_wdata_rdy;
    assign WR_BACK_VALID = r_bvalid;
    assign WR_BACK_ID    = r_bid;
    assign WR_BACK_RESP  = r_bresp;
    assign RD_ADDR_READY = r_raddr_rdy;
    assign RD_DATA       = r_rdata;
    assign RD_BACK_ID    = r_rid;
    assign RD_BACK_RESP  = r_rresp;
    assign RD_DATA_LAST  = r_rlast;
    assign RD_DATA_VALID = r_rvalid;
endmodule

// File: tb/tb_axi_slave_mem.sv
// Self-checking bench for axi_slave_mem: directed vector table, multi-cycle corner
// sequences, and randomized traffic against a word-array reference model.
module tb_axi_slave_mem;
    localparam int DW = 32, IW = 4, AB = 8, AE = 263, RQ = 8, DEP = AE - AB + 1;

    logic clk = 1'b0, rstn = 1'b0;
    logic [31:0] WR_ADDR, RD_ADDR, WR_DATA, RD_DATA;
    logic [7:0]  WR_LEN, RD_LEN;
    logic [IW-1:0] WR_ID, RD_ID, WR_BACK_ID, RD_BACK_ID;
    logic [3:0]  WR_STRB;
    logic [1:0]  WR_BACK_RESP, RD_BACK_RESP;
    logic WR_ADDR_VALID, WR_ADDR_READY, WR_DATA_LAST, WR_DATA_VALID, WR_DATA_READY;
    logic WR_BACK_VALID, WR_BACK_READY, RD_ADDR_VALID, RD_ADDR_READY;
    logic RD_DATA_LAST, RD_DATA_VALID, RD_DATA_READY;

    always #5 clk = ~clk;

    axi_slave_mem #(.DATA_W(DW), .ID_W(IW), .ADDR_B(AB), .ADDR_E(AE), .RD_QUEUE(RQ)) dut (
        .clk(clk), .rstn(rstn),
        .WR_ADDR(WR_ADDR), .WR_LEN(WR_LEN), .WR_ID(WR_ID),
        .WR_ADDR_VALID(WR_ADDR_VALID), .WR_ADDR_READY(WR_ADDR_READY),
        .WR_DATA(WR_DATA), .WR_STRB(WR_STRB), .WR_DATA_LAST(WR_DATA_LAST),
        .WR_DATA_VALID(WR_DATA_VALID), .WR_DATA_READY(WR_DATA_READY),
        .WR_BACK_ID(WR_BACK_ID), .WR_BACK_RESP(WR_BACK_RESP),
        .WR_BACK_VALID(WR_BACK_VALID), .WR_BACK_READY(WR_BACK_READY),
        .RD_ADDR(RD_ADDR), .RD_LEN(RD_LEN), .RD_ID(RD_ID),
        .RD_ADDR_VALID(RD_ADDR_VALID), .RD_ADDR_READY(RD_ADDR_READY),
        .RD_DATA(RD_DATA), .RD_BACK_ID(RD_BACK_ID), .RD_BACK_RESP(RD_BACK_RESP),
        .RD_DATA_LAST(RD_DATA_LAST), .RD_DATA_VALID(RD_DATA_VALID),
        .RD_DATA_READY(RD_DATA_READY)
    );

    int n_cmp = 0, n_bad = 0;
    logic [31:0] mdl [DEP];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];
    logic [31:0] first_beat;
    logic [1:0]  last_resp;

    typedef struct { logic [31:0] addr; int len; logic [IW-1:0] id; } rd_t;
    rd_t rq[$];

    typedef struct {
        bit is_wr; logic [31:0] addr; int len; logic [IW-1:0] id;
        int last_at; logic [3:0] strb; logic [31:0] d0; logic [1:0] resp;
    } vec_t;
    vec_t tbl [15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: handshake bound expired", name);
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        return (a >= 32'(AB)) && (a <= 32'(AE));
    endfunction

    function automatic int widx(input logic [31:0] a, input int k);
        return (int'(a) - AB + k) % DEP;
    endfunction

    task automatic wr_addr(input logic [31:0] a, input int l, input logic [IW-1:0] id, output bit ok);
        int c; bit hs;
        c = 0; hs = 1'b0;
        WR_ADDR = a; WR_LEN = l[7:0]; WR_ID = id; WR_ADDR_VALID = 1'b1;
        while (!hs && c < 50) begin hs = WR_ADDR_READY; @(posedge clk); #1; c++; end
        WR_ADDR_VALID = 1'b0;
        ok = hs;
        if (!hs) fail_now("wr_addr_timeout");
    endtask

    task automatic wr_beat(input logic [31:0] d, input logic [3:0] s, input bit last, output bit ok);
        int c; bit hs;
        c = 0; hs = 1'b0;
        WR_DATA = d; WR_STRB = s; WR_DATA_LAST = last; WR_DATA_VALID = 1'b1;
        while (!hs && c < 50) begin hs = WR_DATA_READY; @(posedge clk); #1; c++; end
        WR_DATA_VALID = 1'b0; WR_DATA_LAST = 1'b0;
        ok = hs;
        if (!hs) fail_now("wr_beat_timeout");
    endtask

    task automatic model_beat(input logic [31:0] a, input int k);
        if (in_rng(a)) begin
            for (int j = 0; j < 4; j++) begin
                if (ws[k][j]) mdl[widx(a, k)][8*j +: 8] = wd[k][8*j +: 8];
            end
        end
    endtask

    task automatic do_write(input logic [31:0] a, input int l, input logic [IW-1:0] id,
                            input int last_at, output logic [1:0] resp, output logic [1:0] mresp);
        bit ok, hs; int nb, c;
        nb    = ((last_at < l) ? last_at : l) + 1;
        mresp = (!in_rng(a) || last_at != l) ? 2'b10 : 2'b00;
        resp  = 2'b11;
        wr_addr(a, l, id, ok);
        if (!ok) return;
        check("wr_data_ready_after_addr", WR_DATA_READY, 1'b1);
        for (int k = 0; k < nb; k++) begin
            wr_beat(wd[k], ws[k], k == last_at, ok);
            if (!ok) return;
            model_beat(a, k);
        end
        check("wr_back_valid_after_last", WR_BACK_VALID, 1'b1);
        check("wr_back_id", WR_BACK_ID, id);
        WR_BACK_READY = 1'b1; c = 0; hs = 1'b0;
        while (!hs && c < 50) begin
            hs = WR_BACK_VALID;
            if (hs) resp = WR_BACK_RESP;
            @(posedge clk); #1; c++;
        end
        WR_BACK_READY = 1'b0;
        if (!hs) fail_now("wr_back_timeout");
        check("wr_back_valid_drop", WR_BACK_VALID, 1'b0);
    endtask

    task automatic rd_issue(input logic [31:0] a, input int l, input logic [IW-1:0] id,
                            input int limit, output bit hs);
        int c;
        rd_t e;
        c = 0; hs = 1'b0;
        RD_ADDR = a; RD_LEN = l[7:0]; RD_ID = id; RD_ADDR_VALID = 1'b1;
        while (!hs && c < limit) begin hs = RD_ADDR_READY; @(posedge clk); #1; c++; end
        RD_ADDR_VALID = 1'b0;
        if (hs) begin
            e.addr = a; e.len = l; e.id = id;
            rq.push_back(e);
        end
    endtask

    task automatic collect(input int nb, input bit throttle);
        rd_t e;
        int c; bit hs, v, lst;
        logic [31:0] d, ed;
        logic [IW-1:0] id;
        logic [1:0] rs;
        for (int b = 0; b < nb; b++) begin
            if (rq.size() == 0) begin fail_now("rd_no_expected_burst"); return; end
            e = rq.pop_front();
            for (int k = 0; k <= e.len; k++) begin
                c = 0; hs = 1'b0;
                while (!hs && c < 200) begin
                    RD_DATA_READY = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
                    v = RD_DATA_VALID; d = RD_DATA; id = RD_BACK_ID;
                    rs = RD_BACK_RESP; lst = RD_DATA_LAST;
                    hs = v & RD_DATA_READY;
                    @(posedge clk); #1; c++;
                end
                if (!hs) begin fail_now("rd_beat_timeout"); RD_DATA_READY = 1'b0; return; end
                ed = in_rng(e.addr) ? mdl[widx(e.addr, k)] : 32'h0;
                if (k == 0) first_beat = d;
                last_resp = rs;
                check("rd_data", d, ed);
                check("rd_id", id, e.id);
                check("rd_resp", rs, in_rng(e.addr) ? 2'b00 : 2'b10);
                check("rd_last", lst, k == e.len);
            end
            check("rd_bubble", RD_DATA_VALID, 1'b0);
        end
        RD_DATA_READY = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok, hs, seen;
        logic [1:0] resp, mresp;
        logic [31:0] a;
        int l, nb;

        tbl[0]  = '{1'b1, 32'h10,  3, 4'h5, 3, 4'hF, 32'h000000A0, 2'b00};
        tbl[1]  = '{1'b0, 32'h10,  3, 4'h6, 0, 4'h0, 32'h000000A0, 2'b00};
        tbl[2]  = '{1'b1, 32'h20,  0, 4'h1, 0, 4'hF, 32'h11223344, 2'b00};
        tbl[3]  = '{1'b1, 32'h20,  0, 4'h2, 0, 4'h5, 32'hAABBCCDD, 2'b00};
        tbl[4]  = '{1'b0, 32'h20,  0, 4'h3, 0, 4'h0, 32'h11BB33DD, 2'b00};
        tbl[5]  = '{1'b1, 32'(AE), 1, 4'h4, 1, 4'hF, 32'h00000001, 2'b00};
        tbl[6]  = '{1'b0, 32'(AE), 1, 4'h7, 0, 4'h0, 32'h00000001, 2'b00};
        tbl[7]  = '{1'b0, 32'(AB), 0, 4'h8, 0, 4'h0, 32'h00000002, 2'b00};
        tbl[8]  = '{1'b1, 32'(AE+1), 0, 4'h8, 0, 4'hF, 32'hDEADBEEF, 2'b10};
        tbl[9]  = '{1'b1, 32'h30,  3, 4'h9, 1, 4'hF, 32'h00000300, 2'b10};
        tbl[10] = '{1'b1, 32'h40,  1, 4'hA, 9, 4'hF, 32'h00000400, 2'b10};
        tbl[11] = '{1'b1, 32'(AB-1), 0, 4'hB, 0, 4'hF, 32'h00000077, 2'b10};
        tbl[12] = '{1'b0, 32'h2000, 1, 4'hC, 0, 4'h0, 32'h00000000, 2'b10};
        tbl[13] = '{1'b0, 32'(AB-1), 0, 4'hD, 0, 4'h0, 32'h00000000, 2'b10};
        tbl[14] = '{1'b0, 32'h80,  1, 4'hE, 0, 4'h0, 32'h00000000, 2'b00};

        for (int i = 0; i < DEP; i++) mdl[i] = 32'h0;
        WR_ADDR = 32'h0; WR_LEN = 8'h0; WR_ID = '0; WR_ADDR_VALID = 1'b0;
        WR_DATA = 32'h0; WR_STRB = 4'h0; WR_DATA_LAST = 1'b0; WR_DATA_VALID = 1'b0;
        WR_BACK_READY = 1'b0; RD_ADDR = 32'h0; RD_LEN = 8'h0; RD_ID = '0;
        RD_ADDR_VALID = 1'b0; RD_DATA_READY = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_handshakes", {WR_ADDR_READY, WR_DATA_READY, WR_BACK_VALID, RD_ADDR_READY,
                                   RD_DATA_VALID, RD_DATA_LAST, WR_BACK_RESP, RD_BACK_RESP}, 10'h0);
        check("reset_payload", {RD_DATA, RD_BACK_ID, WR_BACK_ID}, 40'h0);
        rstn = 1'b1;
        @(posedge clk); #1;
        check("wr_addr_ready_after_reset", WR_ADDR_READY, 1'b1);
        check("rd_addr_ready_after_reset", RD_ADDR_READY, 1'b1);

        for (int i = 0; i < 15; i++) begin
            if (tbl[i].is_wr) begin
                for (int k = 0; k < 16; k++) begin
                    wd[k] = tbl[i].d0 + 32'(k);
                    ws[k] = tbl[i].strb;
                end
                do_write(tbl[i].addr, tbl[i].len, tbl[i].id, tbl[i].last_at, resp, mresp);
                check("tbl_wr_resp", resp, tbl[i].resp);
            end else begin
                rd_issue(tbl[i].addr, tbl[i].len, tbl[i].id, 50, hs);
                if (!hs) fail_now("tbl_rd_addr_timeout");
                collect(1, 1'b0);
                check("tbl_rd_first_beat", first_beat, tbl[i].d0);
                check("tbl_rd_resp", last_resp, tbl[i].resp);
            end
        end

        // first beat must appear two edges after the address handshake
        rd_issue(32'h11, 0, 4'h1, 50, hs);
        check("rd_valid_not_yet", RD_DATA_VALID, 1'b0);
        @(posedge clk); #1;
        check("rd_valid_latency", RD_DATA_VALID, 1'b1);
        collect(1, 1'b0);

        for (int k = 0; k < 4; k++) begin wd[k] = 32'hC0DE0000 + 32'(k); ws[k] = 4'hF; end
        do_write(32'h30, 3, 4'h1, 3, resp, mresp);
        do_write(32'h40, 1, 4'h2, 1, resp, mresp);

        // queue fill with the data channel stalled
        RD_DATA_READY = 1'b0;
        for (int i = 0; i <= RQ; i++) begin
            rd_issue(32'(AB + $urandom_range(0, DEP - 1)), $urandom_range(0, 3), 4'(i), 50, hs);
            if (!hs) fail_now("queue_fill_timeout");
        end
        check("rd_addr_ready_when_full", RD_ADDR_READY, 1'b0);
        rd_issue(32'(AB), 0, 4'hF, 20, hs);
        check("rd_extra_refused", hs, 1'b0);
        collect(RQ + 1, 1'b1);
        if (rq.size() > 0) collect(rq.size(), 1'b0);

        // reset in the middle of both a read and a write burst
        rd_issue(32'h10, 7, 4'h3, 50, hs);
        wr_addr(32'h60, 7, 4'h2, ok);
        for (int k = 0; k < 2; k++) begin
            wd[k] = 32'h60600000 + 32'(k); ws[k] = 4'hF;
            wr_beat(wd[k], ws[k], 1'b0, ok);
            model_beat(32'h60, k);
        end
        #3 rstn = 1'b0;
        #1;
        check("midburst_reset_handshakes", {WR_ADDR_READY, WR_DATA_READY, WR_BACK_VALID,
                                            RD_ADDR_READY, RD_DATA_VALID, RD_DATA_LAST}, 6'h0);
        check("midburst_reset_payload", {RD_DATA, RD_BACK_ID, WR_BACK_ID, RD_BACK_RESP}, 42'h0);
        rq.delete();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        RD_DATA_READY = 1'b1; WR_BACK_READY = 1'b1; seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (RD_DATA_VALID || WR_BACK_VALID || WR_DATA_READY) seen = 1'b1;
        end
        check("no_stale_activity_after_reset", seen, 1'b0);
        RD_DATA_READY = 1'b0; WR_BACK_READY = 1'b0;
        rd_issue(32'h60, 1, 4'h4, 50, hs);
        rd_issue(32'h10, 3, 4'h5, 50, hs);
        collect(2, 1'b0);

        // randomized traffic against the model
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                a = ($urandom_range(0, 9) == 0) ? 32'(AE + 1 + $urandom_range(0, 40))
                                                : 32'(AB + $urandom_range(0, DEP - 1));
                l = $urandom_range(0, 7);
                for (int k = 0; k <= l; k++) begin wd[k] = $urandom; ws[k] = 4'($urandom); end
                do_write(a, l, 4'(it), l, resp, mresp);
                check("rand_wr_resp", resp, mresp);
            end else begin
                nb = $urandom_range(1, 4);
                for (int j = 0; j < nb; j++) begin
                    a = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, AB - 1))
                                                    : 32'(AB + $urandom_range(0, DEP - 1));
                    rd_issue(a, $urandom_range(0, 7), 4'(j + it), 50, hs);
                    if (!hs) fail_now("rand_rd_addr_timeout");
                end
                collect(rq.size(), 1'b1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
